// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the multiply-accumulate sequencing controller.
// Contents: controller state encoding and a small state-decode helper.
package mac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_e;

  // The controller is busy whenever an operation owns the datapath.
  function automatic logic state_is_busy(input mac_state_e st);
    return (st == ACCUM) || (st == DONE);
  endfunction

endpackage

// File: rtl/mac_controller_elem_counter.sv
// Element index counter for the multiply-accumulate controller.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   clr          : synchronous clear to zero (new operation or abort)
//   inc          : advance to the next operand pair
//   len_q        : latched vector length of the current operation
//   idx          : index of the next pair to be accepted
//   last         : idx addresses the final pair (idx == len_q - 1)
module elem_counter #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [LEN_WIDTH-1:0] len_q,
  output logic [LEN_WIDTH-1:0] idx,
  output logic                 last
);

  localparam logic [LEN_WIDTH-1:0] ONE_C = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [LEN_WIDTH-1:0] idx_r;

  // Index register: clear wins over increment, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_r <= {LEN_WIDTH{1'b0}};
    end else if (clr) begin
      idx_r <= {LEN_WIDTH{1'b0}};
    end else if (inc) begin
      idx_r <= idx_r + ONE_C;
    end else begin
      idx_r <= idx_r;
    end
  end

  // The last pair never increments the index, so the maximum length
  // finishes at len_q-1 without wrapping.
  assign last = (idx_r == (len_q - ONE_C));
  assign idx  = idx_r;

endmodule

// File: rtl/mac_controller.sv
// Sequencing controller for a multiply-accumulate dot-product datapath.
// Accepts one operand pair per cycle, steers the accumulate mux, and
// loads the partial-product and final-data registers.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, len            : begin an operation of len pairs (IDLE only)
//   abort                 : cancel an operation in ACCUM
//   in_valid / in_ready   : operand-pair handshake
//   en_Mux                : 0 = add to zero, 1 = add to partial product
//   en_PPReg, en_FDReg    : partial-product / final-data load enables
//   busy, done, len_err   : status (done and len_err are 1-cycle pulses)
//   elem_idx              : index of the next pair to be accepted
module mac_controller
  import mac_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 en_Mux,
  output logic                 en_PPReg,
  output logic                 en_FDReg,
  output logic                 busy,
  output logic                 done,
  output logic                 len_err,
  output logic [LEN_WIDTH-1:0] elem_idx
);

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO_C = {LEN_WIDTH{1'b0}};

  mac_state_e           state_r;
  mac_state_e           state_next_s;
  logic [LEN_WIDTH-1:0] len_q_r;
  logic                 len_err_r;
  logic                 start_ok_s;
  logic                 start_bad_s;
  logic                 xfer_s;
  logic                 last_s;
  logic                 cnt_clr_s;
  logic                 cnt_inc_s;
  logic [LEN_WIDTH-1:0] idx_s;

  assign start_ok_s  = (state_r == IDLE) && start && (len != LEN_ZERO_C);
  assign start_bad_s = (state_r == IDLE) && start && (len == LEN_ZERO_C);
  // abort masks the handshake, so it takes priority over in_valid.
  assign xfer_s      = (state_r == ACCUM) && !abort && in_valid;
  assign cnt_clr_s   = start_ok_s || ((state_r == ACCUM) && abort);
  assign cnt_inc_s   = xfer_s && !last_s;

  elem_counter #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_elem_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cnt_clr_s),
    .inc    (cnt_inc_s),
    .len_q  (len_q_r),
    .idx    (idx_s),
    .last   (last_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Length latch and zero-length error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q_r   <= LEN_ZERO_C;
      len_err_r <= 1'b0;
    end else begin
      len_err_r <= start_bad_s;
      if (start_ok_s) begin
        len_q_r <= len;
      end else begin
        len_q_r <= len_q_r;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (abort) begin
          state_next_s = IDLE;
        end else if (xfer_s && last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ACCUM;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode: enables follow the live handshake in ACCUM.
  always_comb begin
    in_ready = 1'b0;
    en_Mux   = 1'b0;
    en_PPReg = 1'b0;
    en_FDReg = 1'b0;
    done     = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b0;
      end
      ACCUM: begin
        in_ready = !abort;
        en_PPReg = xfer_s;
        en_Mux   = xfer_s && (idx_s != LEN_ZERO_C);
        en_FDReg = xfer_s && last_s;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  assign busy     = state_is_busy(state_r);
  assign len_err  = len_err_r;
  assign elem_idx = idx_s;

endmodule

// File: tb/tb_mac_controller.sv
// Self-checking bench for mac_controller: drives dot-product operations,
// models the accumulate datapath from the enables, and compares final
// results against a scoreboard of expected sums pushed at issue time.
module tb_mac_controller;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] len;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic       en_Mux;
  logic       en_PPReg;
  logic       en_FDReg;
  logic       busy;
  logic       done;
  logic       len_err;
  logic [7:0] elem_idx;

  logic [7:0]  a_op;
  logic [7:0]  b_op;
  logic [31:0] pp_r;
  logic [31:0] fd_r;
  logic [31:0] acc_s;

  int unsigned sb_q[$];
  int n_tests;
  int n_fail;

  mac_controller #(
    .DATA_WIDTH(8),
    .LEN_WIDTH (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .len     (len),
    .abort   (abort),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .en_Mux  (en_Mux),
    .en_PPReg(en_PPReg),
    .en_FDReg(en_FDReg),
    .busy    (busy),
    .done    (done),
    .len_err (len_err),
    .elem_idx(elem_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: multiply, mux-select, accumulate, load on enables.
  assign acc_s = (en_Mux ? pp_r : 32'd0) + ({24'd0, a_op} * {24'd0, b_op});
  always @(posedge clk) begin
    if (en_PPReg) pp_r <= acc_s;
    if (en_FDReg) fd_r <= acc_s;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("result", fd_r, sb_q.pop_front());
      end
    end
  end

  task automatic run_op(input int n, input int av, input int bv, input int stall_at,
                        input int stall_len, input int abort_at, input int exp_lat);
    int xfers;
    int stall_left;
    int cyc;
    bit aborted;
    xfers = 0; stall_left = stall_len; cyc = 0; aborted = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; len = n[7:0]; a_op = av[7:0]; b_op = bv[7:0]; in_valid = 1'b1; abort = 1'b0;
    #1;
    chk("idle_no_ready", in_ready, 32'd0);
    chk("idle_no_pp", en_PPReg, 32'd0);
    if (abort_at < 0) sb_q.push_back(n * av * bv);
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    while (xfers < n && !aborted && cyc < 1000) begin
      if (xfers == stall_at && stall_left > 0) begin
        in_valid = 1'b0; stall_left--;
      end else begin
        in_valid = 1'b1;
      end
      abort = (xfers == abort_at);
      #1;
      chk("elem_idx", elem_idx, xfers);
      chk("busy_accum", busy, 32'd1);
      if (abort) begin
        chk("abort_ready", in_ready, 32'd0);
        chk("abort_pp", en_PPReg, 32'd0);
        chk("abort_fd", en_FDReg, 32'd0);
        aborted = 1'b1;
      end else if (in_valid) begin
        chk("xfer_ready", in_ready, 32'd1);
        chk("xfer_pp", en_PPReg, 32'd1);
        chk("xfer_mux", en_Mux, (xfers != 0) ? 32'd1 : 32'd0);
        chk("xfer_fd", en_FDReg, (xfers == n - 1) ? 32'd1 : 32'd0);
        xfers++;
      end else begin
        chk("stall_pp", en_PPReg, 32'd0);
        chk("stall_mux", en_Mux, 32'd0);
        chk("stall_fd", en_FDReg, 32'd0);
      end
      @(posedge clk); #1;
      cyc++; abort = 1'b0; in_valid = 1'b0;
    end
    if (cyc >= 1000) chk("timeout", 32'd1, 32'd0);
    if (aborted) begin
      #1;
      chk("abort_busy", busy, 32'd0);
      chk("abort_done", done, 32'd0);
      chk("abort_idx", elem_idx, 32'd0);
    end else begin
      // A start presented in DONE must be ignored.
      start = 1'b1; len = 8'd2;
      #1;
      chk("latency", cyc, exp_lat);
      chk("done_pulse", done, 32'd1);
      chk("done_busy", busy, 32'd1);
      chk("done_ready", in_ready, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      chk("done_clear", done, 32'd0);
      chk("start_in_done_ignored", busy, 32'd0);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0; in_valid = 1'b0;
    a_op = 8'd0; b_op = 8'd0;
    #12;
    chk("rst_busy", busy, 32'd0);
    chk("rst_idx", elem_idx, 32'd0);
    chk("rst_done", done, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // len=3, A=2,B=3 -> 18, done 4 cycles after start.
    run_op(3, 2, 3, -1, 0, -1, 4);
    // len=4 with a 2-cycle stall after the second transfer -> done at 7.
    run_op(4, 5, 7, 2, 2, -1, 7);

    // len=0 -> len_err pulse only.
    @(posedge clk); #1;
    start = 1'b1; len = 8'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    chk("len_err_pulse", len_err, 32'd1);
    chk("len_err_busy", busy, 32'd0);
    chk("len_err_pp", en_PPReg, 32'd0);
    chk("len_err_ready", in_ready, 32'd0);
    @(posedge clk); #2;
    chk("len_err_clear", len_err, 32'd0);
    in_valid = 1'b0;

    // Abort after 2 of 5 transfers, then a clean len=2 operation.
    run_op(5, 9, 9, -1, 0, 2, 0);
    run_op(2, 4, 6, -1, 0, -1, 3);

    // Maximum length completes without index wrap.
    run_op(255, 1, 1, -1, 0, -1, 256);

    // Reset in the middle of a len=4 operation.
    @(posedge clk); #1;
    start = 1'b1; len = 8'd4; a_op = 8'd1; b_op = 8'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_idx", elem_idx, 32'd2);
    reset_n = 1'b0; start = 1'b1;
    #1;
    chk("arst_busy", busy, 32'd0);
    chk("arst_ready", in_ready, 32'd0);
    chk("arst_pp", en_PPReg, 32'd0);
    chk("arst_idx", elem_idx, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("start_in_rst_ignored", busy, 32'd0);
    // Release with len=1 start already present: honoured on the first edge.
    #2;
    reset_n = 1'b1; len = 8'd1; a_op = 8'd255; b_op = 8'd255; in_valid = 1'b1;
    sb_q.push_back(32'd65025);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    chk("len1_mux", en_Mux, 32'd0);
    chk("len1_pp", en_PPReg, 32'd1);
    chk("len1_fd", en_FDReg, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("len1_done", done, 32'd1);
    @(posedge clk); #2;
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
